mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 88 ++++++++
 tb/tb_mem_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (fetch/data) memory arbiter with timeout; define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module mem_port_arbiter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] rdata,
    output logic          rerr,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, nxt;
    logic owner_dm, pick_dm, arb, done;
    logic [7:0] cnt;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_dm;
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_dm <= 1'b0;
        else if (arb) last_dm <= pick_dm;
    assign pick_dm = dm_req && !(if_req && last_dm);
`else
    assign pick_dm = dm_req;
`endif
    assign arb  = state != ACCESS && (if_req || dm_req);
    // mem_ready takes precedence over an expiring counter in the same cycle
    assign done = state == ACCESS && (mem_ready || cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;

    always_comb
        nxt = state == ACCESS ? (done ? RESP : ACCESS) : (arb ? ACCESS : IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_dm  <= 1'b0;
            cnt       <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            rdata     <= '0;
            rerr      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_gnt    <= arb && !pick_dm;
            dm_gnt    <= arb && pick_dm;
            if_rvalid <= done && !owner_dm;
            dm_rvalid <= done && owner_dm;
            mem_en    <= nxt == ACCESS;
            busy      <= nxt != IDLE;
            cnt       <= state == ACCESS ? cnt + 8'd1 : 8'd0;
            if (arb) begin
                owner_dm  <= pick_dm;
                mem_we    <= pick_dm && dm_we;
                mem_addr  <= pick_dm ? dm_addr : if_addr;
                mem_wdata <= pick_dm ? dm_wdata : '0;
            end
            if (done) begin
                rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
                rerr  <= !mem_ready;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of mem_port_arbiter against a timing/arbitration model.
module tb_mem_port_arbiter;
    localparam int AW = 64, DW = 64, TO = 15;
    logic clk = 1'b0, reset = 1'b0;
    logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
    logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, rerr, mem_en, mem_we, busy;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    int n_cmp = 0, n_bad = 0;
    logic last_dm = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic exp_rerr = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .rdata(rdata), .rerr(rerr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycle();
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = rnd64();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_en", mem_en, 0);
        check("idle_gnt", {if_gnt, dm_gnt}, 0);
        check("idle_rvalid", {if_rvalid, dm_rvalid}, 0);
        check("idle_rdata", rdata, exp_rdata);
        check("idle_rerr", rerr, exp_rerr);
    endtask

    // k = ACCESS cycle (1-based) on which memory answers; k > TO means never
    task automatic txn(int k, logic [DW-1:0] rd);
        logic w, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int n;
`ifdef ARB_ROUND_ROBIN_EN
        w = dm_req && !(if_req && last_dm);
`else
        w = dm_req;
`endif
        last_dm = w;
        a  = w ? dm_addr : if_addr;
        we = w && dm_we;
        wd = w ? dm_wdata : '0;
        n  = k <= TO ? k : TO;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            check("gnt", {if_gnt, dm_gnt}, c == 1 ? (w ? 2'b01 : 2'b10) : 2'b00);
            check("acc_en", mem_en, 1);
            check("acc_addr", mem_addr, a);
            check("acc_we", mem_we, we);
            check("acc_wdata", mem_wdata, wd);
            check("acc_busy", busy, 1);
            check("acc_rvalid", {if_rvalid, dm_rvalid}, 0);
            if (c == 1) begin
                if (w) dm_req = 1'b0;
                else if_req = 1'b0;
            end
            mem_ready = c == k;
            mem_rdata = c == k ? rd : rnd64();
        end
        exp_rdata = (k <= TO && !we) ? rd : '0;
        exp_rerr  = k > TO;
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        check("resp_rvalid", {if_rvalid, dm_rvalid}, w ? 2'b01 : 2'b10);
        check("resp_rdata", rdata, exp_rdata);
        check("resp_rerr", rerr, exp_rerr);
        check("resp_en", mem_en, 0);
        check("resp_busy", busy, 1);
        check("resp_gnt", {if_gnt, dm_gnt}, 0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ctl"}, {if_gnt, if_rvalid, dm_gnt, dm_rvalid, rerr, mem_en, mem_we, busy}, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mwdata"}, mem_wdata, 0);
    endtask

    initial begin
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        if_req = 1'b1;
        if_addr = 64'h40;
        txn(2, 64'h00500093);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h8; dm_wdata = 64'hDEAD;
        txn(1, rnd64());
        idle_cycle();
        for (int i = 0; i < 4; i++) begin
            if_req = 1'b1; if_addr = rnd64();
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = rnd64();
            txn(1, rnd64());
        end
        while (if_req || dm_req) txn(1, rnd64());
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
        txn(TO + 1, rnd64());
        dm_req = 1'b1; dm_addr = 64'h108;
        txn(TO, 64'h1234_5678);
        for (int i = 0; i < 300; i++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = rnd64();
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = rnd64(); dm_wdata = rnd64();
            end
            if (if_req || dm_req)
                txn($urandom_range(0, 7) == 0 ? TO + 1 : int'($urandom_range(1, 4)), rnd64());
            else
                idle_cycle();
        end
        while (if_req || dm_req) txn(1, rnd64());
        idle_cycle();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200; mem_ready = 1'b0;
        @(negedge clk);
        dm_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b1;
        last_dm = 1'b0; exp_rdata = '0; exp_rerr = 1'b0;
        for (int i = 0; i < 3; i++) idle_cycle();
        if_req = 1'b1; dm_req = 1'b1; if_addr = 64'h300; dm_addr = 64'h308; dm_we = 1'b0;
        txn(1, rnd64());
        while (if_req || dm_req) txn(2, rnd64());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
